// File: rtl/accept_decider.sv
// Accept/reject decider for annealing moves: downhill moves accept at once, uphill
// moves are settled by an LFSR draw against an externally computed probability.
//
// state     | meaning
// IDLE      | ready for a candidate; downhill moves are decided here directly
// WAIT_PROB | uphill move issued, waiting for prob_valid or the wait timeout
module accept_decider #(
    parameter logic [31:0] TINV_INIT      = 32'h0000_0100,
    parameter logic [31:0] TINV_STEP      = 32'h0000_0010,
    parameter int unsigned STEPS_PER_TEMP = 1000,
    parameter logic [31:0] LFSR_SEED      = 32'hACE1_2468,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cand_valid,
    output logic        cand_ready,
    input  logic [31:0] new_cost,
    input  logic [31:0] old_cost,
    output logic        prob_req,
    output logic [31:0] prob_new,
    output logic [31:0] prob_old,
    output logic [31:0] tinv,
    input  logic [31:0] prob,
    input  logic        prob_valid,
    output logic        dec_valid,
    output logic        dec_accept,
    output logic        timeout_err,
    output logic [31:0] accept_count
);

    typedef enum logic {IDLE, WAIT_PROB} state_t;

    localparam logic [31:0] LFSR_MASK   = 32'h8020_0003;
    localparam logic [31:0] LFSR_INIT   = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
    localparam logic [31:0] STEPS_LIM   = 32'(STEPS_PER_TEMP);
    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT);

    state_t      state_q, state_d;
    logic        cand_ready_q, cand_ready_d;
    logic        prob_req_q, prob_req_d;
    logic [31:0] prob_new_q, prob_new_d;
    logic [31:0] prob_old_q, prob_old_d;
    logic [31:0] wait_q, wait_d;
    logic        dec_valid_q, dec_valid_d;
    logic        dec_accept_q, dec_accept_d;
    logic        timeout_err_q, timeout_err_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] dec_cnt_q, dec_cnt_d;
    logic [31:0] tinv_q, tinv_d;
    logic [31:0] accept_cnt_q, accept_cnt_d;
    logic [32:0] tinv_sum;

    // Only the Q0.24 fraction of prob takes part in the draw.
    logic unused_prob_hi;
    assign unused_prob_hi = ^prob[31:24];

    always_comb begin
        state_d       = state_q;
        prob_req_d    = 1'b0;
        prob_new_d    = prob_new_q;
        prob_old_d    = prob_old_q;
        wait_d        = wait_q;
        dec_valid_d   = 1'b0;
        dec_accept_d  = 1'b0;
        timeout_err_d = timeout_err_q;

        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (cand_valid && cand_ready_q) begin
                    if (new_cost > old_cost) begin
                        prob_new_d = new_cost;
                        prob_old_d = old_cost;
                        prob_req_d = 1'b1;
                        wait_d     = 32'd1;
                        state_d    = WAIT_PROB;
                    end else begin
                        dec_valid_d  = 1'b1;
                        dec_accept_d = 1'b1;
                    end
                end
            end
            WAIT_PROB: begin
                // wait_q holds the number of cycles spent here, current one included
                if (prob_valid) begin
                    dec_valid_d  = 1'b1;
                    dec_accept_d = (lfsr_q[23:0] < prob[23:0]);
                    wait_d       = '0;
                    state_d      = IDLE;
                end else if (wait_q == TIMEOUT_LIM) begin
                    dec_valid_d   = 1'b1;
                    timeout_err_d = 1'b1;
                    wait_d        = '0;
                    state_d       = IDLE;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        cand_ready_d = (state_d == IDLE);
        lfsr_d       = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);

        dec_cnt_d    = dec_cnt_q;
        tinv_d       = tinv_q;
        accept_cnt_d = accept_cnt_q;
        tinv_sum     = {1'b0, tinv_q} + {1'b0, TINV_STEP};
        if (dec_valid_d) begin
            if (dec_cnt_q + 32'd1 == STEPS_LIM) begin
                dec_cnt_d = '0;
                tinv_d    = tinv_sum[32] ? 32'hFFFF_FFFF : tinv_sum[31:0];
            end else begin
                dec_cnt_d = dec_cnt_q + 32'd1;
            end
            if (dec_accept_d) begin
                accept_cnt_d = accept_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cand_ready_q  <= 1'b0;
            prob_req_q    <= 1'b0;
            prob_new_q    <= '0;
            prob_old_q    <= '0;
            wait_q        <= '0;
            dec_valid_q   <= 1'b0;
            dec_accept_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            lfsr_q        <= LFSR_INIT;
            dec_cnt_q     <= '0;
            tinv_q        <= TINV_INIT;
            accept_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            cand_ready_q  <= cand_ready_d;
            prob_req_q    <= prob_req_d;
            prob_new_q    <= prob_new_d;
            prob_old_q    <= prob_old_d;
            wait_q        <= wait_d;
            dec_valid_q   <= dec_valid_d;
            dec_accept_q  <= dec_accept_d;
            timeout_err_q <= timeout_err_d;
            lfsr_q        <= lfsr_d;
            dec_cnt_q     <= dec_cnt_d;
            tinv_q        <= tinv_d;
            accept_cnt_q  <= accept_cnt_d;
        end
    end

    assign cand_ready   = cand_ready_q;
    assign prob_req     = prob_req_q;
    assign prob_new     = prob_new_q;
    assign prob_old     = prob_old_q;
    assign tinv         = tinv_q;
    assign dec_valid    = dec_valid_q;
    assign dec_accept   = dec_accept_q;
    assign timeout_err  = timeout_err_q;
    assign accept_count = accept_cnt_q;

endmodule
